priority_scan: RTL

Parametrised, multi-cycle most/least-significant-set-bit finder for wide words. It accepts one word per transaction over a valid/ready handshake and scans it CHUNK bits per cycle, exiting early on the first non-zero chunk. It returns the bit index with an explicit found flag, replacing the 8-bit combinational MSB encoder and its all-ones "no bit" code. It sits between register-file/status sources and arbitration or normalisation logic that needs a bit index from words wider than one cycle of priority logic can handle.

---
 rtl/priority_scan.sv | 135 +++++++++++++
 1 files changed

// File: rtl/priority_scan.sv
`default_nettype none
// ============================================================================
//  Module      : priority_scan
//  Description : Multi-cycle highest/lowest set-bit finder for wide words.
//                Accepts one word per valid/ready transaction and scans it
//                CHUNK bits per cycle. The scan stops at the first non-zero
//                chunk and the result is the bit index plus a found flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_scan #(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int NCH   = WIDTH / CHUNK,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_found
);

    localparam int PTR_W = (NCH > 1)   ? $clog2(NCH)   : 1;
    localparam int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    localparam logic [PTR_W-1:0] c_first_ptr = '0;
    localparam logic [PTR_W-1:0] c_last_ptr  = PTR_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic               r_lsb;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_index;
    logic               r_out_found;

    logic [IDX_W-1:0]   w_base;
    logic [CHUNK-1:0]   w_chunk;
    logic [OFF_W-1:0]   w_off;
    logic               w_hit;
    logic               w_last;
    logic [IDX_W-1:0]   w_index;

    // The only combinational output: ready exactly while idle and out of reset.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_found = r_out_found;

    // Select the chunk under the pointer and locate its highest/lowest set bit.
    always_comb begin
        w_base  = IDX_W'(r_ptr) * IDX_W'(CHUNK);
        w_chunk = r_data[w_base +: CHUNK];
        w_hit   = |w_chunk;
        w_off   = '0;
        if (r_lsb) begin
            // Descending sweep: the lowest set bit is written last.
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (w_chunk[i]) w_off = OFF_W'(i);
            end
        end else begin
            // Ascending sweep: the highest set bit is written last.
            for (int i = 0; i < CHUNK; i++) begin
                if (w_chunk[i]) w_off = OFF_W'(i);
            end
        end
        w_index = w_base + IDX_W'(w_off);
        w_last  = r_lsb ? (r_ptr == c_last_ptr) : (r_ptr == c_first_ptr);
    end

    // Handshake and scan state machine with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_lsb       <= 1'b0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_found <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_lsb   <= in_lsb_mode;
                        r_ptr   <= in_lsb_mode ? c_first_ptr : c_last_ptr;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_out_index <= w_index;
                        r_out_found <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_last) begin
                        // Word was all zeros: report an explicit miss.
                        r_out_index <= '0;
                        r_out_found <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_lsb) begin
                        r_ptr <= r_ptr + PTR_W'(1);
                    end else begin
                        r_ptr <= r_ptr - PTR_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
